// File: rtl/posit_decoder_stage.sv
// Streaming posit decoder: raw posit in, sign/scale/fraction/zero/NaR out; optional input skid via POSIT_DECODER_SKID_EN.
// Latency 2 cycles accept->pd_out_rts; 1 word/cycle. Full backpressure: stages hold while pd_out_rtr=0.
// Base build: rtr_in combinational from pd_out_rtr. SKID_EN build: rtr_in from a flop, 2-entry skid absorbs the lag.
package posit_decoder_pkg;
    localparam int PD_NORMAL = 0;
    localparam int PD_WIDE   = 1;

    function automatic int get_scale_width(input int n, input int es, input int pd_type);
        return $clog2((n - 1) << es) + ((pd_type == PD_WIDE) ? 2 : 1);
    endfunction

    function automatic int get_fraction_width(input int n, input int es, input int pd_type);
        int w;
        w = (pd_type == PD_WIDE) ? n - 2 : n - 3 - es;
        return (w < 1) ? 1 : w;
    endfunction
endpackage

module posit_decoder_stage
    import posit_decoder_pkg::*;
#(
    parameter int POSIT_WIDTH = 16,
    parameter int POSIT_ES    = 1,
    parameter int PD_TYPE     = PD_NORMAL,
    localparam int SW = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE),
    localparam int FW = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rts_in,
    output logic                   rtr_in,
    input  logic                   sow_in,
    input  logic                   eow_in,
    input  logic [POSIT_WIDTH-1:0] posit_in,
    output logic                   pd_out_rts,
    input  logic                   pd_out_rtr,
    output logic                   pd_out_sow,
    output logic                   pd_out_eow,
    output logic [SW-1:0]          pd_out_scale,
    output logic [FW-1:0]          pd_out_fraction,
    output logic                   pd_out_nar,
    output logic                   pd_out_sign,
    output logic                   pd_out_zero,
    output logic                   pd_out_guard,
    output logic                   pd_out_round,
    output logic                   pd_out_sticky
);
    localparam int N    = POSIT_WIDTH;
    localparam int BODY = N - 1;
    localparam int EW   = (POSIT_ES > 0) ? POSIT_ES : 1;

    logic            adv1, adv2, rdy_q;
    logic            src_vld, src_sow, src_eow;
    logic [N-1:0]    src_posit;

    logic            v1, s1_sign, s1_sow, s1_eow, s1_zero, s1_nar;
    logic [BODY-1:0] s1_mag;

    assign adv2 = !pd_out_rts || pd_out_rtr;
    assign adv1 = !v1 || adv2;

`ifdef POSIT_DECODER_SKID_EN
    logic [N+1:0] skid_q [2];
    logic [1:0]   skid_cnt, cnt_nxt;
    logic         acc, take_direct, pop, push, wr_idx;

    assign acc         = rts_in && rdy_q;
    assign pop         = adv1 && (skid_cnt != 2'd0);
    assign take_direct = acc && adv1 && (skid_cnt == 2'd0);
    assign push        = acc && !take_direct;
    assign cnt_nxt     = skid_cnt + 2'(push) - 2'(pop);
    assign wr_idx      = !pop && skid_cnt[0];
    assign src_vld     = pop || take_direct;
    assign {src_sow, src_eow, src_posit} = pop ? skid_q[0] : {sow_in, eow_in, posit_in};
    assign rtr_in      = rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_cnt  <= 2'd0;
            rdy_q     <= 1'b0;
            skid_q[0] <= '0;
            skid_q[1] <= '0;
        end else begin
            skid_cnt <= cnt_nxt;
            rdy_q    <= (cnt_nxt != 2'd2);
            if (pop)
                skid_q[0] <= skid_q[1];
            // A push into the slot being vacated by the pop must win, so it comes last.
            if (push)
                skid_q[wr_idx] <= {sow_in, eow_in, posit_in};
        end
    end
`else
    assign src_vld   = rts_in && rtr_in;
    assign src_sow   = sow_in;
    assign src_eow   = eow_in;
    assign src_posit = posit_in;
    assign rtr_in    = rdy_q && adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdy_q <= 1'b0;
        else
            rdy_q <= 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_mag  <= '0;
            s1_sow  <= 1'b0;
            s1_eow  <= 1'b0;
            s1_zero <= 1'b0;
            s1_nar  <= 1'b0;
        end else if (adv1) begin
            v1 <= src_vld;
            if (src_vld) begin
                s1_sign <= src_posit[N-1];
                // Low bits of -p depend only on low bits of p; the MSB only matters for NaR.
                s1_mag  <= src_posit[N-1] ? (~src_posit[BODY-1:0] + BODY'(1)) : src_posit[BODY-1:0];
                s1_sow  <= src_sow;
                s1_eow  <= src_eow;
                s1_zero <= (src_posit == '0);
                s1_nar  <= (src_posit == {1'b1, {BODY{1'b0}}});
            end
        end
    end

    logic            lead, run;
    int              r, k, sc;
    logic [BODY-1:0] shifted;
    logic [BODY+FW-1:0] ext;
    logic [EW-1:0]   e_val;
    logic [FW-1:0]   frac_val;
    logic [SW-1:0]   scale_val;

    always_comb begin
        lead = s1_mag[BODY-1];
        run  = 1'b1;
        r    = 0;
        for (int i = BODY - 1; i >= 0; i--) begin
            if (run && (s1_mag[i] == lead))
                r = r + 1;
            else
                run = 1'b0;
        end
        shifted   = s1_mag << (r + 1);
        ext       = {shifted, {FW{1'b0}}};
        e_val     = EW'(ext >> (BODY + FW - POSIT_ES));
        frac_val  = FW'(ext >> (BODY - POSIT_ES));
        k         = lead ? r - 1 : -r;
        sc        = (k * (1 << POSIT_ES)) + int'(e_val);
        scale_val = SW'(sc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pd_out_rts      <= 1'b0;
            pd_out_sow      <= 1'b0;
            pd_out_eow      <= 1'b0;
            pd_out_scale    <= '0;
            pd_out_fraction <= '0;
            pd_out_nar      <= 1'b0;
            pd_out_sign     <= 1'b0;
            pd_out_zero     <= 1'b0;
        end else if (adv2) begin
            pd_out_rts <= v1;
            if (v1) begin
                pd_out_sow      <= s1_sow;
                pd_out_eow      <= s1_eow;
                pd_out_sign     <= s1_sign;
                pd_out_zero     <= s1_zero;
                pd_out_nar      <= s1_nar;
                pd_out_scale    <= (s1_zero || s1_nar) ? '0 : scale_val;
                pd_out_fraction <= (s1_zero || s1_nar) ? '0 : frac_val;
            end
        end
    end

    // Decoding is exact, so no rounding information is ever produced.
    assign pd_out_guard  = 1'b0;
    assign pd_out_round  = 1'b0;
    assign pd_out_sticky = 1'b0;
endmodule

// File: tb/tb_posit_decoder_stage.sv
// Scoreboard bench for posit_decoder_stage (N=16, ES=1) with a bit-queue reference decoder.
module tb_posit_decoder_stage;
    import posit_decoder_pkg::*;

    localparam int N  = 16;
    localparam int ES = 1;
    localparam int SW = get_scale_width(N, ES, PD_NORMAL);
    localparam int FW = get_fraction_width(N, ES, PD_NORMAL);
`ifdef POSIT_DECODER_SKID_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 2;
`endif

    logic          clk = 1'b0;
    logic          rst_n, rts_in, rtr_in, sow_in, eow_in;
    logic [N-1:0]  posit_in;
    logic          pd_out_rts, pd_out_rtr, pd_out_sow, pd_out_eow;
    logic [SW-1:0] pd_out_scale;
    logic [FW-1:0] pd_out_fraction;
    logic          pd_out_nar, pd_out_sign, pd_out_zero, pd_out_guard, pd_out_round, pd_out_sticky;

    posit_decoder_stage #(.POSIT_WIDTH(N), .POSIT_ES(ES), .PD_TYPE(PD_NORMAL)) dut (
        .clk(clk), .rst_n(rst_n), .rts_in(rts_in), .rtr_in(rtr_in), .sow_in(sow_in),
        .eow_in(eow_in), .posit_in(posit_in), .pd_out_rts(pd_out_rts), .pd_out_rtr(pd_out_rtr),
        .pd_out_sow(pd_out_sow), .pd_out_eow(pd_out_eow), .pd_out_scale(pd_out_scale),
        .pd_out_fraction(pd_out_fraction), .pd_out_nar(pd_out_nar), .pd_out_sign(pd_out_sign),
        .pd_out_zero(pd_out_zero), .pd_out_guard(pd_out_guard), .pd_out_round(pd_out_round),
        .pd_out_sticky(pd_out_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sign, zero, nar, sow, eow;
        int            scale;
        logic [FW-1:0] frac;
        int            acc;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0, n_err = 0, n_out = 0, cyc = 0;
    bit   lat_chk = 0;

    logic [63:0] all_out;
    assign all_out = 64'({pd_out_rts, pd_out_sow, pd_out_eow, pd_out_scale, pd_out_fraction,
                          pd_out_nar, pd_out_sign, pd_out_zero, pd_out_guard, pd_out_round, pd_out_sticky});

    always @(posedge clk) cyc++;

    function automatic exp_t mk(bit sg, bit z, bit nr, int sc, logic [FW-1:0] fr);
        exp_t x;
        x.sign = sg; x.zero = z; x.nar = nr; x.scale = sc; x.frac = fr;
        x.sow = 0; x.eow = 0; x.acc = 0;
        return x;
    endfunction

    // Reference decode: walk the posit body as a list of bits.
    function automatic exp_t model(logic [N-1:0] p);
        exp_t x;
        int   m, r, k, ev;
        bit   bits[$];
        bit   first;
        x = mk(0, 0, 0, 0, '0);
        if (p == '0) begin
            x.zero = 1;
        end else if (int'(p) == (1 << (N - 1))) begin
            x.nar = 1; x.sign = 1;
        end else begin
            x.sign = p[N-1];
            m = x.sign ? (1 << N) - int'(p) : int'(p);
            for (int i = N - 2; i >= 0; i--) bits.push_back(((m >> i) & 1) == 1);
            first = bits[0];
            r = 0;
            while (bits.size() > 0 && bits[0] == first) begin
                void'(bits.pop_front());
                r++;
            end
            k = first ? r - 1 : -r;
            if (bits.size() > 0) void'(bits.pop_front());
            ev = 0;
            for (int j = 0; j < ES; j++) ev = ev * 2 + ((bits.size() > 0) ? int'(bits.pop_front()) : 0);
            for (int j = 0; j < FW; j++) x.frac = {x.frac[FW-2:0], (bits.size() > 0) ? bits.pop_front() : 1'b0};
            x.scale = k * (2 ** ES) + ev;
        end
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic drive(input bit vrts, input logic [N-1:0] w, input bit s, input bit e, input bit orr,
                         input bit have_x, input exp_t xo, output bit acc);
        exp_t x;
        @(negedge clk);
        rts_in = vrts; posit_in = w; sow_in = s; eow_in = e; pd_out_rtr = orr;
        #1;
        acc = rts_in && rtr_in && rst_n;
        if (acc) begin
            x = have_x ? xo : model(w);
            x.sow = s; x.eow = e; x.acc = cyc;
            sbq.push_back(x);
        end
    endtask

    task automatic send(input logic [N-1:0] w, input bit have_x, input exp_t xo);
        bit a;
        int t;
        a = 0; t = 0;
        while (!a && t < 200) begin
            drive(1, w, 0, 0, 1, have_x, xo, a);
            t++;
        end
        check("send_accepted", 64'(a), 64'd1);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 1, 0, mk(0, 0, 0, 0, '0), a);
    endtask

    // Monitor: one comparison per transfer on the output side.
    initial begin
        exp_t x;
        bit   ok;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && pd_out_rts && pd_out_rtr) begin
                n_out++;
                n_vec++;
                if (sbq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: got scale=%0d frac=%0h zero=%b nar=%b required no output",
                             $signed(pd_out_scale), pd_out_fraction, pd_out_zero, pd_out_nar);
                end else begin
                    x  = sbq.pop_front();
                    ok = (pd_out_sign === x.sign) && (pd_out_zero === x.zero) && (pd_out_nar === x.nar) &&
                         (pd_out_sow === x.sow) && (pd_out_eow === x.eow) &&
                         (int'($signed(pd_out_scale)) == x.scale) && (pd_out_fraction === x.frac) &&
                         ({pd_out_guard, pd_out_round, pd_out_sticky} === 3'b000);
                    if (!ok) begin
                        n_err++;
                        $display("FAIL decode: got s=%b z=%b n=%b sow=%b eow=%b sc=%0d fr=%0h grs=%b%b%b required s=%b z=%b n=%b sow=%b eow=%b sc=%0d fr=%0h grs=000",
                                 pd_out_sign, pd_out_zero, pd_out_nar, pd_out_sow, pd_out_eow,
                                 $signed(pd_out_scale), pd_out_fraction, pd_out_guard, pd_out_round, pd_out_sticky,
                                 x.sign, x.zero, x.nar, x.sow, x.eow, x.scale, x.frac);
                    end
                    if (lat_chk) begin
                        n_vec++;
                        if (cyc - x.acc != 2) begin
                            n_err++;
                            $display("FAIL latency: got %0d cycles required 2", cyc - x.acc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] dw [8];
        exp_t         dx [8];
        logic [N-1:0] sw [8];
        logic [N-1:0] w;
        bit           a, s, e, pend, prts;
        int           idx, c, sent, cb, out_before, sel;

        rst_n = 0; rts_in = 0; sow_in = 0; eow_in = 0; posit_in = '0; pd_out_rtr = 0;
        #2;
        check("reset_outputs", all_out, 64'd0);
        check("reset_rtr_in", 64'(rtr_in), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        #1 check("rtr_in_before_first_edge", 64'(rtr_in), 64'd0);
        @(negedge clk);
        #1 check("rtr_in_after_release", 64'(rtr_in), 64'd1);

        // Directed decodes, back to back with the sink always ready.
        dw[0] = 16'h4000; dx[0] = mk(0, 0, 0, 0, 12'h000);
        dw[1] = 16'h5000; dx[1] = mk(0, 0, 0, 1, 12'h000);
        dw[2] = 16'h4800; dx[2] = mk(0, 0, 0, 0, 12'h800);
        dw[3] = 16'h0001; dx[3] = mk(0, 0, 0, -28, 12'h000);
        dw[4] = 16'h7FFF; dx[4] = mk(0, 0, 0, 28, 12'h000);
        dw[5] = 16'hC000; dx[5] = mk(1, 0, 0, 0, 12'h000);
        dw[6] = 16'h0000; dx[6] = mk(0, 1, 0, 0, 12'h000);
        dw[7] = 16'h8000; dx[7] = mk(1, 0, 1, 0, 12'h000);
        lat_chk = 1;
        for (int i = 0; i < 8; i++) send(dw[i], 1, dx[i]);
        idle(6);
        lat_chk = 0;
        check("directed_drain", 64'(sbq.size()), 64'd0);

        // Sink stalled for 5 cycles while 8 tagged words stream in.
        for (int i = 0; i < 8; i++) sw[i] = N'($urandom);
        idx = 0; c = 0;
        while (idx < 8 && c < 100) begin
            drive(1, sw[idx], idx == 0, idx == 7, c >= 5, 0, mk(0, 0, 0, 0, '0), a);
            if (a) idx++;
            if (c == 4) check("stall_fill", 64'(idx), 64'(CAP));
            c++;
        end
        check("stall_all_sent", 64'(idx), 64'd8);
        idle(20);
        check("stall_drain", 64'(sbq.size()), 64'd0);

        // Reset with two words in flight.
        send(16'h5A5A, 0, mk(0, 0, 0, 0, '0));
        send(16'hA5A5, 0, mk(0, 0, 0, 0, '0));
        @(negedge clk);
        rts_in = 0; pd_out_rtr = 0;
        #3 check("inflight_before_reset", 64'(pd_out_rts), 64'd1);
        rst_n = 0;
        #1 check("midreset_outputs", all_out, 64'd0);
        check("midreset_rtr_in", 64'(rtr_in), 64'd0);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        out_before = n_out;
        idle(10);
        check("post_reset_silence", 64'(n_out - out_before), 64'd0);

        // Random traffic with random backpressure on both sides.
        sent = 0; cb = 0; pend = 0; w = '0; s = 0; e = 0; prts = 0;
        while (sent < 10000 && cb < 60000) begin
            if (!pend) begin
                sel = $urandom_range(0, 15);
                if (sel == 0)      w = '0;
                else if (sel == 1) w = 16'h8000;
                else if (sel == 2) w = N'($urandom_range(1, 7));
                else if (sel == 3) w = 16'h8000 | N'($urandom_range(1, 7));
                else               w = N'($urandom);
                s = 1'($urandom_range(0, 1));
                e = 1'($urandom_range(0, 1));
                prts = ($urandom_range(0, 3) != 0);
            end
            drive(prts, w, s, e, $urandom_range(0, 3) != 0, 0, mk(0, 0, 0, 0, '0), a);
            if (a) begin
                sent++;
                pend = 0;
            end else begin
                pend = prts;
            end
            cb++;
        end
        check("random_words_sent", 64'(sent), 64'd10000);
        idle(20);
        check("random_drain", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
